gate_op_arbiter: RTL and testbench

- Shares one registered WIDTH-bit multi-function gate unit (AND/OR/XOR/NOT/XNOR/NAND/NOR/PASS) among NREQ requesters.
- Arbitration is round-robin. Each transaction is a single operation with a result handshake.
- Sits between the gate-level datapath and any number of client blocks that previously instantiated private gate logic.
- Only one operation is in flight at a time.

---
 rtl/gate_op_arbiter_if.sv | 28 ++
 rtl/gate_op_arbiter.sv | 137 +++++++++++++
 tb/tb_gate_op_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between client blocks and the shared gate-op unit.
// Per-requester fields are packed side by side, requester i at slice i.
interface gate_op_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a_in;
  logic [WIDTH*NREQ-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      result;

  modport master (
    output req, op, a_in, b_in, res_ready,
    input  gnt, busy, res_valid, res_id, result
  );

  modport slave (
    input  req, op, a_in, b_in, res_ready,
    output gnt, busy, res_valid, res_id, result
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin shared bitwise gate unit: one operation in flight, IDLE -> EXEC -> RESP,
// every output driven straight from a register.
module gate_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  gate_op_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_valid_q, res_valid_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Winner search: smallest round-robin distance from last among set req bits.
  logic             found;
  logic [IDW-1:0]   win_id;
  logic [NREQ-1:0]  win_oh;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;

  always_comb begin
    int best_d;
    int d;
    found  = 1'b0;
    win_id = '0;
    win_oh = '0;
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    best_d = NREQ + 1;
    d      = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = j - int'(last_q);
      if (d <= 0) d = d + NREQ;
      if (bus.req[j] && d < best_d) begin
        best_d    = d;
        found     = 1'b1;
        win_id    = IDW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_op    = bus.op[3*j +: 3];
        win_a     = bus.a_in[WIDTH*j +: WIDTH];
        win_b     = bus.b_in[WIDTH*j +: WIDTH];
      end
    end
  end

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    gate_f = a & b;
      3'd1:    gate_f = a | b;
      3'd2:    gate_f = a ^ b;
      3'd3:    gate_f = ~a;
      3'd4:    gate_f = ~(a ^ b);
      3'd5:    gate_f = ~(a & b);
      3'd6:    gate_f = ~(a | b);
      default: gate_f = a;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    last_d      = last_q;
    res_id_d    = res_id_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    case (state_q)
      IDLE: if (found) begin
        gnt_d    = win_oh;
        op_d     = win_op;
        a_d      = win_a;
        b_d      = win_b;
        res_id_d = win_id;
        last_d   = win_id;
        state_d  = EXEC;
      end
      EXEC: begin
        result_d    = gate_f(op_q, a_q, b_q);
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= IDW'(NREQ - 1);
      res_id_q    <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      res_id_q    <= res_id_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scenario bench for gate_op_arbiter: directed round-robin/opcode/backpressure/reset
// cases plus randomized transactions against a truth-table reference model.
module tb_gate_op_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   m_last;

  logic [WIDTH-1:0] exp_tbl [8] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'h33, 8'hCF, 8'h03, 8'hF0};
  logic [2:0]       r_op [NREQ];
  logic [WIDTH-1:0] r_a  [NREQ];
  logic [WIDTH-1:0] r_b  [NREQ];

  gate_op_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
  gate_op_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin rule: first requester set, scanning last+1, last+2, ... modulo NREQ.
  function automatic int exp_win(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  // Each opcode as a 2-input truth table indexed by {a,b}, applied bit by bit.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [3:0]       tt;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: tt = 4'b1000;  3'd1: tt = 4'b1110;  3'd2: tt = 4'b0110;  3'd3: tt = 4'b0011;
      3'd4: tt = 4'b1001;  3'd5: tt = 4'b0111;  3'd6: tt = 4'b0001;  default: tt = 4'b1100;
    endcase
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic set_req(input int i, input logic [2:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    bus.op[3*i +: 3]           = o;
    bus.a_in[WIDTH*i +: WIDTH] = a;
    bus.b_in[WIDTH*i +: WIDTH] = b;
    r_op[i] = o; r_a[i] = a; r_b[i] = b;
  endtask

  task automatic wait_gnt(output bit ok);
    for (int i = 0; i < 20 && bus.gnt == '0; i++) @(negedge clk);
    ok = (bus.gnt != '0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && bus.busy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.a_in = '0; bus.b_in = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.req = '1;
    @(negedge clk);
    n_chk++; if (bus.gnt !== '0) $display("FAIL rst_gnt: got %b want 0", bus.gnt); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.res_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.res_valid); else n_pass++;
    n_chk++; if (bus.res_id !== '0 || bus.result !== '0)
      $display("FAIL rst_res: got id=%0d res=%h want 0/00", bus.res_id, bus.result); else n_pass++;
    m_last = NREQ - 1;
  endtask

  task automatic test_rr_all();
    bit ok; int w; int prev;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd1, WIDTH'(i + 1), WIDTH'((i + 1) << 4));
    bus.res_ready = 1'b1;
    rst = 1'b0;
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(ok);
      w = exp_win(bus.req, m_last);
      n_chk++; if (!ok || bus.gnt !== oh(w)) $display("FAIL rr_gnt%0d: got %b want %b", t, bus.gnt, oh(w)); else n_pass++;
      if (prev >= 0) begin
        n_chk++; if (cyc - prev != 3) $display("FAIL rr_gap%0d: got %0d want 3", t, cyc - prev); else n_pass++;
      end
      prev = cyc; m_last = w;
      @(negedge clk);
      n_chk++; if (bus.res_valid !== 1'b1 || bus.res_id !== IDW'(w) || bus.result !== ref_op(r_op[w], r_a[w], r_b[w]))
        $display("FAIL rr_res%0d: got v=%b id=%0d res=%h want 1/%0d/%h", t, bus.res_valid, bus.res_id, bus.result,
                 w, ref_op(r_op[w], r_a[w], r_b[w])); else n_pass++;
    end
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_ops();
    bus.res_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      set_req(2, 3'(o), 8'hF0, 8'h3C);
      bus.req = 4'b0100;
      @(negedge clk);
      n_chk++; if (bus.gnt !== 4'b0100 || bus.res_valid !== 1'b0)
        $display("FAIL op%0d_gnt: got gnt=%b v=%b want 0100/0", o, bus.gnt, bus.res_valid); else n_pass++;
      bus.req = '0;
      @(negedge clk);
      n_chk++; if (bus.res_valid !== 1'b1 || bus.result !== exp_tbl[o] || bus.res_id !== 3'd2)
        $display("FAIL op%0d_res: got v=%b res=%h id=%0d want 1/%h/2", o, bus.res_valid, bus.result, bus.res_id, exp_tbl[o]);
      else n_pass++;
      @(negedge clk);
    end
    m_last = 2;
  endtask

  task automatic test_backpressure();
    int w; logic [WIDTH-1:0] r;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    bus.res_ready = 1'b0;
    bus.req = 4'b1011;
    w = exp_win(4'b1011, m_last);
    @(negedge clk);
    n_chk++; if (bus.gnt !== oh(w)) $display("FAIL bp_gnt: got %b want %b", bus.gnt, oh(w)); else n_pass++;
    m_last = w;
    @(negedge clk);
    r = ref_op(r_op[w], r_a[w], r_b[w]);
    n_chk++; if (bus.res_valid !== 1'b1 || bus.result !== r)
      $display("FAIL bp_res: got v=%b res=%h want 1/%h", bus.res_valid, bus.result, r); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.res_valid !== 1'b1 || bus.result !== r || bus.res_id !== IDW'(w) || bus.gnt !== '0 || bus.busy !== 1'b1)
        $display("FAIL bp_hold%0d: got v=%b res=%h id=%0d gnt=%b busy=%b want 1/%h/%0d/0/1", c, bus.res_valid,
                 bus.result, bus.res_id, bus.gnt, bus.busy, r, w);
      else n_pass++;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.res_valid !== 1'b0 || bus.gnt !== '0)
      $display("FAIL bp_ack: got v=%b gnt=%b want 0/0", bus.res_valid, bus.gnt); else n_pass++;
    @(negedge clk);
    w = exp_win(4'b1011, m_last);
    n_chk++; if (bus.gnt !== oh(w)) $display("FAIL bp_next: got %b want %b", bus.gnt, oh(w)); else n_pass++;
    m_last = w;
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_capture();
    int w;
    bus.res_ready = 1'b1;
    set_req(1, 3'd2, 8'h55, 8'h0F);
    bus.req = 4'b0010;
    w = exp_win(4'b0010, m_last);
    @(negedge clk);
    n_chk++; if (bus.gnt !== oh(w)) $display("FAIL cap_gnt: got %b want %b", bus.gnt, oh(w)); else n_pass++;
    m_last = w;
    bus.op[5:3] = 3'd0; bus.a_in[15:8] = 8'hFF; bus.b_in[15:8] = 8'hFF;
    bus.req = '0;
    @(negedge clk);
    n_chk++; if (bus.result !== 8'h5A || bus.res_id !== 3'd1)
      $display("FAIL cap_res: got res=%h id=%0d want 5a/1", bus.result, bus.res_id); else n_pass++;
    wait_idle();
  endtask

  task automatic test_alt13();
    bit ok; int w;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd7, WIDTH'(8'hA0 + i), 8'h00);
    bus.res_ready = 1'b1;
    bus.req = 4'b1010;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(ok);
      w = exp_win(bus.req, m_last);
      n_chk++; if (!ok || bus.gnt !== oh(w)) $display("FAIL alt_gnt%0d: got %b want %b", t, bus.gnt, oh(w)); else n_pass++;
      m_last = w;
      if (t < 4) @(negedge clk);
    end
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.req = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (bus.gnt !== '0) $display("FAIL alt_resp_gnt%0d: got %b want 0", c, bus.gnt); else n_pass++;
    end
    bus.res_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_gnt(ok);
      w = exp_win(bus.req, m_last);
      n_chk++; if (!ok || bus.gnt !== oh(w)) $display("FAIL alt_late%0d: got %b want %b", t, bus.gnt, oh(w)); else n_pass++;
      m_last = w;
      @(negedge clk);
    end
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_async_reset();
    bus.res_ready = 1'b0;
    set_req(1, 3'd1, 8'h12, 8'h34);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0)
      $display("FAIL arst_exec: got gnt=%b busy=%b v=%b want 0/0/0", bus.gnt, bus.busy, bus.res_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b0; m_last = NREQ - 1;
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0001) $display("FAIL arst_exec_next: got %b want 0001", bus.gnt); else n_pass++;
    m_last = 0;
    bus.req = '0;
    @(negedge clk);
    n_chk++; if (bus.res_valid !== 1'b1) $display("FAIL arst_resp_pre: got %b want 1", bus.res_valid); else n_pass++;
    bus.req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.result !== '0 || bus.res_id !== '0)
      $display("FAIL arst_resp: got gnt=%b busy=%b v=%b res=%h id=%0d want 0/0/0/00/0", bus.gnt, bus.busy,
               bus.res_valid, bus.result, bus.res_id);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; m_last = NREQ - 1;
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0001) $display("FAIL arst_resp_next: got %b want 0001", bus.gnt); else n_pass++;
    m_last = 0;
    bus.req = '0; bus.res_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_random();
    int w; int k; logic [NREQ-1:0] r; logic [WIDTH-1:0] er;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bus.req = r; bus.res_ready = 1'b0;
      w = exp_win(r, m_last);
      er = ref_op(r_op[w], r_a[w], r_b[w]);
      @(negedge clk);
      n_chk++; if (bus.gnt !== oh(w) || bus.busy !== 1'b1 || bus.res_valid !== 1'b0)
        $display("FAIL rnd%0d_gnt: got gnt=%b busy=%b v=%b want %b/1/0", t, bus.gnt, bus.busy, bus.res_valid, oh(w));
      else n_pass++;
      bus.req = '0;
      bus.op = 12'($urandom); bus.a_in = 32'($urandom); bus.b_in = 32'($urandom);
      @(negedge clk);
      n_chk++; if (bus.res_valid !== 1'b1 || bus.result !== er || bus.res_id !== IDW'(w))
        $display("FAIL rnd%0d_res: got v=%b res=%h id=%0d want 1/%h/%0d", t, bus.res_valid, bus.result, bus.res_id, er, w);
      else n_pass++;
      k = $urandom_range(0, 4);
      for (int c = 0; c < k; c++) begin
        @(negedge clk);
        n_chk++; if (bus.res_valid !== 1'b1 || bus.result !== er || bus.gnt !== '0)
          $display("FAIL rnd%0d_hold: got v=%b res=%h gnt=%b want 1/%h/0", t, bus.res_valid, bus.result, bus.gnt, er);
        else n_pass++;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL rnd%0d_ack: got v=%b busy=%b want 0/0", t, bus.res_valid, bus.busy); else n_pass++;
      m_last = w;
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_ops();
    test_backpressure();
    test_capture();
    test_alt13();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
